// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding carried in the top two bits of every flit.
package noc_pkg;

    typedef enum logic [1:0] {
        FLIT_IDLE   = 2'b00,
        FLIT_HEADER = 2'b01,
        FLIT_BODY   = 2'b10,
        FLIT_TAIL   = 2'b11
    } flit_type_t;

    function automatic logic is_header_type(input logic [1:0] type_bits);
        return flit_type_t'(type_bits) == FLIT_HEADER;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Flit storage for the FIFO: register array with a synchronous write port and an
// asynchronous read port. Contents are never reset.
module fifo_mem
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo.sv
// Show-ahead single-clock flit FIFO holding one packet; captures the last header's destination.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH   = 18,
    parameter int FIFO_SIZE    = 64,
    parameter int ADDRESS_SIZE = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           rd_en,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(FIFO_SIZE+1)-1:0] count,
    output logic [ADDRESS_SIZE-1:0]        pkt_address
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                           overflow,
    output logic                           underflow
`endif
);

    localparam int PTR_W = $clog2(FIFO_SIZE);
    localparam int CNT_W = $clog2(FIFO_SIZE + 1);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(FIFO_SIZE - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_SIZE);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             wr_accept;
    logic             rd_accept;

    // Explicit wrap so depths that are not powers of two still cycle correctly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign wr_accept = wr_en && (!full || rd_en);
    assign rd_accept = rd_en && !empty;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_SIZE),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_accept) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_address <= '0;
        end else if (wr_accept && is_header_type(wr_data[DATA_WIDTH-1 -: 2])) begin
            pkt_address <= wr_data[ADDRESS_SIZE-1:0];
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky until reset so software can spot a misbehaving upstream after the fact.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full && !rd_en) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: queue-based reference model compared every cycle,
// plus directed literal checks for reset, fill/overflow, drain, simultaneous ops and headers.
module tb_fifo;

    localparam int DW   = 18;
    localparam int SIZE = 64;
    localparam int AW   = 4;
    localparam int CW   = $clog2(SIZE + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic [AW-1:0] pkt_address;
`ifdef FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q[$];
    logic [AW-1:0] model_addr;
    bit            model_on = 1'b0;

    fifo #(
        .DATA_WIDTH   (DW),
        .FIFO_SIZE    (SIZE),
        .ADDRESS_SIZE (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .pkt_address (pkt_address)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [DW-1:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain queue with pop-then-push ordering on each edge.
    always @(posedge clk) begin
        if (rst) begin
            model_q.delete();
            model_addr = '0;
            model_on   = 1'b1;
        end else if (model_on) begin
            bit do_wr;
            bit do_rd;
            do_rd = rd_en && (model_q.size() > 0);
            do_wr = wr_en && ((model_q.size() < SIZE) || rd_en);
            if (do_rd) void'(model_q.pop_front());
            if (do_wr) begin
                model_q.push_back(wr_data);
                if (wr_data[DW-1 -: 2] == 2'b01) model_addr = wr_data[AW-1:0];
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("model_count", 32'(count), 32'(model_q.size()));
            checkOutput("model_empty", 32'(empty), 32'(model_q.size() == 0));
            checkOutput("model_full", 32'(full), 32'(model_q.size() == SIZE));
            checkOutput("model_pkt_address", 32'(pkt_address), 32'(model_addr));
            if (model_q.size() > 0) begin
                checkOutput("model_rd_data", 32'(rd_data), 32'(model_q[0]));
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_full", 32'(full), 32'd0);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_pkt_address", 32'(pkt_address), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);

        for (int i = 0; i < SIZE; i++) applyStimulus(1'b1, DW'(i), 1'b0);
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_count", 32'(count), 32'd64);

        applyStimulus(1'b1, 18'h3FFFF, 1'b0);
        checkOutput("overflow_count", 32'(count), 32'd64);
        checkOutput("overflow_head", 32'(rd_data), 32'd0);

        for (int i = 0; i < SIZE; i++) begin
            checkOutput("drain_order", 32'(rd_data), 32'(i));
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);
        checkOutput("drain_count", 32'(count), 32'd0);

        for (int i = 0; i < SIZE; i++) applyStimulus(1'b1, DW'(i + 100), 1'b0);
        applyStimulus(1'b1, 18'h15555, 1'b1);
        checkOutput("simul_full_count", 32'(count), 32'd64);
        checkOutput("simul_full_full", 32'(full), 32'd1);
        for (int i = 1; i < SIZE; i++) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("simul_full_last", 32'(rd_data), 32'h15555);
        checkOutput("simul_full_addr", 32'(pkt_address), 32'h5);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("simul_full_empty", 32'(empty), 32'd1);

        applyStimulus(1'b1, 18'h00123, 1'b1);
        checkOutput("simul_empty_count", 32'(count), 32'd1);
        checkOutput("simul_empty_data", 32'(rd_data), 32'h00123);
        applyStimulus(1'b0, '0, 1'b1);

        applyStimulus(1'b1, 18'h1000A, 1'b0);
        checkOutput("header_addr", 32'(pkt_address), 32'hA);
        applyStimulus(1'b1, 18'h20003, 1'b0);
        applyStimulus(1'b1, 18'h30005, 1'b0);
        checkOutput("tail_addr_hold", 32'(pkt_address), 32'hA);
        checkOutput("packet_count", 32'(count), 32'd3);

        for (int i = 0; i < 200; i++) begin
            logic w;
            logic r;
            w = (i < 100) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            r = (i < 100) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            applyStimulus(w, DW'($urandom), r);
        end

        applyStimulus(1'b1, 18'h1000C, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 18'h10007, 1'b1);
        checkOutput("midreset_count", 32'(count), 32'd0);
        checkOutput("midreset_empty", 32'(empty), 32'd1);
        checkOutput("midreset_addr", 32'(pkt_address), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
